// File: rtl/resp_misr_pkg.sv
// rtl/resp_misr_pkg.sv - shared state encoding and default constants for the response MISR analyzer
package resp_misr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    COMPACT = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'h0000;

endpackage

// File: rtl/misr_core.sv
// rtl/misr_core.sv - two-input multiple-input signature register datapath
module misr_core #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [1:0]       din_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q, sig_d;

  // load has priority so a new run always starts from SEED
  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
              ^ {{(SIG_W-2){1'b0}}, din_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/resp_misr_analyzer.sv
// rtl/resp_misr_analyzer.sv - skips CUT flush cycles, compacts PO1/PO2 into a MISR, compares to golden
module resp_misr_analyzer
  import resp_misr_pkg::*;
#(
  parameter int               SIG_W     = 16,
  parameter logic [SIG_W-1:0] POLY      = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED      = SIG_W'(DEF_SEED),
  parameter int               CNT_W     = 16,
  parameter int               FLUSH_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] num_cycles_i,
  input  logic [SIG_W-1:0] golden_sig_i,
  input  logic             po1_i,
  input  logic             po2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [SIG_W-1:0] signature_o
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, fcnt_q;
  logic             busy_q, done_q, pass_q;
  logic [SIG_W-1:0] sig;
  logic [SIG_W-1:0] sig_fold;
  logic             misr_load, misr_en;

  assign misr_load = (state_q == IDLE) && start_i;
  assign misr_en   = (state_q == COMPACT) && !abort_i;

  misr_core #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (misr_load),
    .en_i    (misr_en),
    .din_i   ({po2_i, po1_i}),
    .sig_o   (sig)
  );

  // value the MISR takes on this edge, needed to grade the final compaction edge
  assign sig_fold = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0)
                    ^ {{(SIG_W-2){1'b0}}, po2_i, po1_i};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (state_q != IDLE && abort_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_q  <= num_cycles_i;
            fcnt_q <= CNT_W'(FLUSH_CYC);
            pass_q <= 1'b0;
            busy_q <= 1'b1;
            if (FLUSH_CYC > 0) begin
              state_q <= FLUSH;
            end else if (num_cycles_i != '0) begin
              state_q <= COMPACT;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= (SEED == golden_sig_i);
            end
          end
        end
        FLUSH: begin
          fcnt_q <= fcnt_q - CNT_W'(1);
          if (fcnt_q == CNT_W'(1)) begin
            if (cnt_q == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= (sig == golden_sig_i);
            end else begin
              state_q <= COMPACT;
            end
          end
        end
        COMPACT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (sig_fold == golden_sig_i);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign signature_o = sig;

endmodule

// File: tb/tb_resp_misr_analyzer.sv
// tb/tb_resp_misr_analyzer.sv - self-checking bench for resp_misr_analyzer
module tb_resp_misr_analyzer;

  localparam logic [15:0] POLY = 16'h1021;

  logic        clk = 1'b0;
  logic        rst_n, start_a, start_b, abort, po1, po2;
  logic [15:0] num_cycles, golden;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] sig_a, sig_b;

  always #5 clk = ~clk;

  resp_misr_analyzer #(.SIG_W(16), .POLY(16'h1021), .SEED(16'h0000), .CNT_W(16), .FLUSH_CYC(2)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .abort_i(abort), .num_cycles_i(num_cycles),
    .golden_sig_i(golden), .po1_i(po1), .po2_i(po2), .busy_o(busy_a), .done_o(done_a),
    .pass_o(pass_a), .signature_o(sig_a));

  resp_misr_analyzer #(.SIG_W(16), .POLY(16'h1021), .SEED(16'h8000), .CNT_W(16), .FLUSH_CYC(0)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .abort_i(abort), .num_cycles_i(num_cycles),
    .golden_sig_i(golden), .po1_i(po1), .po2_i(po2), .busy_o(busy_b), .done_o(done_b),
    .pass_o(pass_b), .signature_o(sig_b));

  int n_pass = 0;
  int n_tot  = 0;
  int cur_sel = 0;

  logic        busy_m, done_m, pass_m;
  logic [15:0] sig_m;
  assign busy_m = (cur_sel != 0) ? busy_b : busy_a;
  assign done_m = (cur_sel != 0) ? done_b : done_a;
  assign pass_m = (cur_sel != 0) ? pass_b : pass_a;
  assign sig_m  = (cur_sel != 0) ? sig_b  : sig_a;

  // multiply by x modulo x^16 + POLY, then add the two response bits
  function automatic logic [15:0] fold(input logic [15:0] s, input logic [1:0] d);
    logic [16:0] w;
    w = {s, 1'b0};
    if (w[16]) w = w ^ {1'b1, POLY};
    return w[15:0] ^ {14'd0, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic set_start(input logic v);
    if (cur_sel != 0) start_b = v;
    else start_a = v;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          sel;
    int          n;
    int          pat;
    logic [15:0] gold;
    bit          repulse;
    logic [15:0] exp_sig;
    bit          exp_pass;
  } vec_t;

  task automatic run(input vec_t v);
    int          flush, f;
    logic [15:0] seed, m, part, g, exp_sig;
    bit          exp_pass;
    logic [1:0]  po_q[$];
    flush = (v.sel != 0) ? 0 : 2;
    seed  = (v.sel != 0) ? 16'h8000 : 16'h0000;
    f     = flush + v.n;
    po_q.delete();
    for (int j = 0; j < f; j++) begin
      if (j < flush || v.pat == 2) po_q.push_back(2'($urandom));
      else if (v.pat == 1 && j == flush) po_q.push_back(2'b01);
      else po_q.push_back(2'b00);
    end
    m = seed;
    for (int k = flush; k < f; k++) m = fold(m, po_q[k]);
    if (v.pat == 2) begin
      g        = ($urandom_range(0, 1) != 0) ? m : (m ^ (16'h1 << $urandom_range(0, 15)));
      exp_sig  = m;
      exp_pass = (g == m);
    end else begin
      g        = v.gold;
      exp_sig  = v.exp_sig;
      exp_pass = v.exp_pass;
    end
    cur_sel    = v.sel;
    num_cycles = 16'(v.n);
    part       = seed;
    for (int j = 0; j <= f + 1; j++) begin
      set_start((j == 0) ? 1'b1 : (v.repulse ? 1'($urandom_range(0, 1)) : 1'b0));
      golden = (j == f) ? g : 16'($urandom);
      {po2, po1} = (j >= 1 && j <= f) ? po_q[j-1] : 2'($urandom);
      edge_wait();
      if (j > flush && j <= f) part = fold(part, po_q[j-1]);
      chk("busy", busy_m, (j <= f) ? 1 : 0);
      chk("done", done_m, (j == f) ? 1 : 0);
      chk("pass", pass_m, (j >= f) ? exp_pass : 1'b0);
      chk("signature", sig_m, (j >= f) ? exp_sig : part);
    end
    set_start(1'b0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 4, 1, 16'h0008, 1'b0, 16'h0008, 1'b1};
    tbl[1] = '{0, 4, 1, 16'h0008, 1'b1, 16'h0008, 1'b1};
    tbl[2] = '{1, 1, 0, 16'h1021, 1'b0, 16'h1021, 1'b1};
    tbl[3] = '{1, 0, 0, 16'h8000, 1'b0, 16'h8000, 1'b1};
    tbl[4] = '{1, 0, 0, 16'h8001, 1'b0, 16'h8000, 1'b0};
    tbl[5] = '{0, 0, 0, 16'h0000, 1'b0, 16'h0000, 1'b1};
    tbl[6] = '{0, 3, 0, 16'h0001, 1'b0, 16'h0000, 1'b0};
    tbl[7] = '{1, 2, 1, 16'h2040, 1'b0, 16'h2040, 1'b1};

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    po1 = 1'b0; po2 = 1'b0; num_cycles = '0; golden = '0;
    edge_wait();
    edge_wait();
    rst_n = 1'b1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_sig", sig_a, 16'h0000);
    chk("rst_sig_b", sig_b, 16'h8000);

    for (int i = 0; i < 8; i++) run(tbl[i]);

    // abort in IDLE is a no-op; start wins over a simultaneous abort
    cur_sel = 1;
    abort = 1'b1;
    edge_wait();
    chk("idle_abort_pass", pass_b, 1);
    chk("idle_abort_busy", busy_b, 0);
    start_b = 1'b1; num_cycles = 16'd3; {po2, po1} = 2'b00;
    edge_wait();
    chk("start_wins_busy", busy_b, 1);
    chk("start_wins_pass", pass_b, 0);
    start_b = 1'b0; abort = 1'b0;
    edge_wait();
    chk("compact_sig", sig_b, 16'h1021);
    abort = 1'b1;
    edge_wait();
    abort = 1'b0;
    chk("abort_busy", busy_b, 0);
    chk("abort_done", done_b, 0);
    chk("abort_pass", pass_b, 0);
    chk("abort_sig", sig_b, 16'h1021);
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      chk("abort_no_done", done_b, 0);
    end

    // abort while in DONE clears pass
    cur_sel = 0;
    start_a = 1'b1; num_cycles = 16'd1; {po2, po1} = 2'b00; golden = 16'h0000;
    edge_wait();
    start_a = 1'b0;
    for (int i = 0; i < 3; i++) edge_wait();
    chk("pre_abort_done", done_a, 1);
    chk("pre_abort_pass", pass_a, 1);
    abort = 1'b1;
    edge_wait();
    abort = 1'b0;
    chk("done_abort_pass", pass_a, 0);
    chk("done_abort_busy", busy_a, 0);

    // reset in the middle of compaction
    start_a = 1'b1; num_cycles = 16'd6; po1 = 1'b1; po2 = 1'b1;
    edge_wait();
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) edge_wait();
    chk("pre_rst_busy", busy_a, 1);
    rst_n = 1'b0;
    edge_wait();
    rst_n = 1'b1;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_pass", pass_a, 0);
    chk("midrst_sig", sig_a, 16'h0000);
    chk("midrst_sig_b", sig_b, 16'h8000);
    run(tbl[0]);

    for (int i = 0; i < 12; i++) begin
      vec_t r;
      r.sel = $urandom_range(0, 1);
      r.n = $urandom_range(1, 20);
      r.pat = 2;
      r.gold = '0;
      r.repulse = 1'($urandom_range(0, 1));
      r.exp_sig = '0;
      r.exp_pass = 1'b0;
      run(r);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
